alu_mc: RTL and testbench

Multi-cycle, parametrised ALU that replaces the single-cycle 32-bit ALU in the execute stage. It keeps the add/sub, shift, logic and three-way compare operations and adds iterative unsigned multiply and divide. Results are registered and exchanged with valid/ready handshakes, so the core can stall on long operations. One operation is in flight at a time.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_comb.sv | 47 ++++
 rtl/alu_mc.sv | 145 ++++++++++++++
 tb/tb_alu_mc.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared types for the multi-cycle ALU: opcodes, FSM states, GES bit positions.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD   = 4'd0,
        OP_SUB   = 4'd1,
        OP_SLL   = 4'd2,
        OP_SRL   = 4'd3,
        OP_SRA   = 4'd4,
        OP_XOR   = 4'd5,
        OP_OR    = 4'd6,
        OP_AND   = 4'd7,
        OP_MUL   = 4'd8,
        OP_MULHU = 4'd9,
        OP_DIVU  = 4'd10,
        OP_REMU  = 4'd11
    } alu_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DIV  = 2'd2,
        S_DONE = 2'd3
    } alu_state_e;

    localparam int GES_GT = 2;
    localparam int GES_EQ = 1;
    localparam int GES_LT = 0;

endpackage

// File: rtl/alu_comb.sv
// Single-cycle datapath: add/sub, barrel shifts, logic ops and three-way compare.
module alu_comb
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [3:0]       op,
    input  logic             cmp_signed,
    output logic [WIDTH-1:0] result,
    output logic [2:0]       ges
);

    logic [SHW-1:0] sh;
    logic           lt;
    logic           eq;

    assign sh = b[SHW-1:0];
    assign eq = (a == b);
    assign lt = cmp_signed ? ($signed(a) < $signed(b)) : (a < b);

    always_comb begin
        ges         = '0;
        ges[GES_GT] = !lt && !eq;
        ges[GES_EQ] = eq;
        ges[GES_LT] = lt;
    end

    // Non-single-cycle opcodes yield zero so the top can register this blindly.
    always_comb begin
        result = '0;
        case (op)
            OP_ADD: result = a + b;
            OP_SUB: result = a - b;
            OP_SLL: result = a << sh;
            OP_SRL: result = a >> sh;
            OP_SRA: result = $signed(a) >>> sh;
            OP_XOR: result = a ^ b;
            OP_OR:  result = a | b;
            OP_AND: result = a & b;
            default: result = '0;
        endcase
    end

endmodule

// File: rtl/alu_mc.sv
// Multi-cycle ALU with valid/ready handshakes; shift-add multiply, restoring divide.
// Define ALU_DIV_EN to build the divider; otherwise DIVU/REMU report illegal_op.
module alu_mc
    import alu_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] Arg1,
    input  logic [WIDTH-1:0] Arg2,
    input  logic [3:0]       ALU_Control,
    input  logic             cmp_signed,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] ALUResult,
    output logic [2:0]       GES,
    output logic             illegal_op
);

    localparam logic [SHW:0] LAST = (SHW+1)'(WIDTH-1);

    alu_state_e       state;
    logic [WIDTH-1:0] hi, lo, opnd;
    logic [SHW:0]     cnt;
    logic             hi_sel;
    logic [WIDTH-1:0] comb_res;
    logic [2:0]       comb_ges;
    logic             illegal;
    logic             accept;
    logic [WIDTH:0]   add_a, add_b, add_s, mul_s;
    logic             sub;
    logic [WIDTH-1:0] nxt_hi, nxt_lo;

    alu_comb #(.WIDTH(WIDTH), .SHW(SHW)) u_comb (
        .a          (Arg1),
        .b          (Arg2),
        .op         (ALU_Control),
        .cmp_signed (cmp_signed),
        .result     (comb_res),
        .ges        (comb_ges)
    );

    assign in_ready = (state == S_IDLE);
    assign accept   = in_valid && in_ready;

`ifdef ALU_DIV_EN
    assign illegal = (ALU_Control > 4'(OP_REMU));
`else
    assign illegal = (ALU_Control > 4'(OP_MULHU));
`endif

    // hi/lo hold {product high, multiplier} for MUL and {remainder, quotient} for DIV.
    always_comb begin
        add_a = {1'b0, hi};
        add_b = {1'b0, opnd};
        sub   = 1'b0;
`ifdef ALU_DIV_EN
        if (state == S_DIV) begin
            add_a = {hi, lo[WIDTH-1]};
            sub   = 1'b1;
        end
`endif
        add_s  = add_a + (sub ? ~add_b : add_b) + (WIDTH+1)'(sub);
        mul_s  = lo[0] ? add_s : {1'b0, hi};
        nxt_hi = mul_s[WIDTH:1];
        nxt_lo = {mul_s[0], lo[WIDTH-1:1]};
`ifdef ALU_DIV_EN
        // Remainder is always below the divisor, so add_s[WIDTH] is the borrow.
        if (state == S_DIV) begin
            nxt_hi = add_s[WIDTH] ? add_a[WIDTH-1:0] : add_s[WIDTH-1:0];
            nxt_lo = {lo[WIDTH-2:0], ~add_s[WIDTH]};
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= S_IDLE;
            out_valid  <= 1'b0;
            ALUResult  <= '0;
            GES        <= '0;
            illegal_op <= 1'b0;
            cnt        <= '0;
            hi         <= '0;
            lo         <= '0;
            opnd       <= '0;
            hi_sel     <= 1'b0;
        end else begin
            case (state)
                S_IDLE: if (accept) begin
                    GES        <= comb_ges;
                    illegal_op <= illegal;
                    hi_sel     <= ALU_Control[0];
                    cnt        <= '0;
                    hi         <= '0;
                    case (ALU_Control)
                        OP_MUL, OP_MULHU: begin
                            state <= S_MUL;
                            lo    <= Arg2;
                            opnd  <= Arg1;
                        end
`ifdef ALU_DIV_EN
                        OP_DIVU, OP_REMU: begin
                            if (Arg2 == '0) begin
                                state     <= S_DONE;
                                out_valid <= 1'b1;
                                ALUResult <= ALU_Control[0] ? Arg1 : '1;
                            end else begin
                                state <= S_DIV;
                                lo    <= Arg1;
                                opnd  <= Arg2;
                            end
                        end
`endif
                        default: begin
                            state     <= S_DONE;
                            out_valid <= 1'b1;
                            ALUResult <= comb_res;
                        end
                    endcase
                end
                S_MUL, S_DIV: begin
                    hi  <= nxt_hi;
                    lo  <= nxt_lo;
                    cnt <= cnt + (SHW+1)'(1);
                    if (cnt == LAST) begin
                        state     <= S_DONE;
                        out_valid <= 1'b1;
                        ALUResult <= hi_sel ? nxt_hi : nxt_lo;
                    end
                end
                S_DONE: if (out_ready) begin
                    state     <= S_IDLE;
                    out_valid <= 1'b0;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_mc.sv
// Directed and random checks of alu_mc against a queue of bench-computed results.
module tb_alu_mc;

    localparam int W = 32;
`ifdef ALU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic         in_ready;
    logic [W-1:0] Arg1 = '0;
    logic [W-1:0] Arg2 = '0;
    logic [3:0]   ALU_Control = '0;
    logic         cmp_signed = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b0;
    logic [W-1:0] ALUResult;
    logic [2:0]   GES;
    logic         illegal_op;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic [W-1:0] r;
        logic [2:0]   g;
        logic         ill;
        int           lat;
        string        tag;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    alu_mc #(.WIDTH(W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .Arg1        (Arg1),
        .Arg2        (Arg2),
        .ALU_Control (ALU_Control),
        .cmp_signed  (cmp_signed),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .ALUResult   (ALUResult),
        .GES         (GES),
        .illegal_op  (illegal_op)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [3:0] op, input logic [W-1:0] a,
                                   input logic [W-1:0] b, input logic cs, input string tag);
        exp_t        e;
        logic [63:0] p;
        p     = {32'b0, a} * {32'b0, b};
        e.tag = tag;
        e.ill = 1'b0;
        e.lat = 1;
        e.r   = '0;
        if (cs ? ($signed(a) > $signed(b)) : (a > b)) e.g = 3'b100;
        else if (a == b)                               e.g = 3'b010;
        else                                           e.g = 3'b001;
        case (op)
            4'd0: e.r = a + b;
            4'd1: e.r = a - b;
            4'd2: e.r = a << b[4:0];
            4'd3: e.r = a >> b[4:0];
            4'd4: e.r = $signed(a) >>> b[4:0];
            4'd5: e.r = a ^ b;
            4'd6: e.r = a | b;
            4'd7: e.r = a & b;
            4'd8: begin e.r = p[31:0];  e.lat = W + 1; end
            4'd9: begin e.r = p[63:32]; e.lat = W + 1; end
            4'd10, 4'd11: begin
                if (!DIV_EN) e.ill = 1'b1;
                else if (b == 0) e.r = (op == 4'd10) ? 32'hFFFF_FFFF : a;
                else begin
                    e.r   = (op == 4'd10) ? a / b : a % b;
                    e.lat = W + 1;
                end
            end
            default: e.ill = 1'b1;
        endcase
        return e;
    endfunction

    // Drive one request for a single edge, then scramble the inputs to prove latching.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic cs, input string tag);
        chk({tag, "_in_ready"}, in_ready, 1);
        ALU_Control = op;
        Arg1        = a;
        Arg2        = b;
        cmp_signed  = cs;
        in_valid    = 1'b1;
        sb.push_back(model(op, a, b, cs, tag));
        @(posedge clk); #1;
        in_valid    = 1'b0;
        Arg1        = $urandom;
        Arg2        = $urandom;
        ALU_Control = 4'($urandom);
        cmp_signed  = ~cs;
    endtask

    task automatic collect(input int hold);
        exp_t e;
        int   lat;
        lat = 1;
        while (!out_valid && lat < 200) begin
            @(posedge clk); #1;
            lat++;
        end
        chk("sb_nonempty", sb.size() != 0, 1);
        if (sb.size() == 0) return;
        e = sb.pop_front();
        chk({e.tag, "_valid"},   out_valid,  1);
        chk({e.tag, "_latency"}, lat,        e.lat);
        chk({e.tag, "_result"},  ALUResult,  e.r);
        chk({e.tag, "_ges"},     GES,        e.g);
        chk({e.tag, "_illegal"}, illegal_op, e.ill);
        repeat (hold) begin
            @(posedge clk); #1;
            chk({e.tag, "_hold_valid"},  out_valid, 1);
            chk({e.tag, "_hold_ready"},  in_ready,  0);
            chk({e.tag, "_hold_result"}, ALUResult, e.r);
            chk({e.tag, "_hold_ges"},    GES,       e.g);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        chk({e.tag, "_ack_valid"}, out_valid, 0);
        chk({e.tag, "_ack_ready"}, in_ready,  1);
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_valid",   out_valid,  0);
        chk("rst_ready",   in_ready,   1);
        chk("rst_result",  ALUResult,  0);
        chk("rst_ges",     GES,        0);
        chk("rst_illegal", illegal_op, 0);
        rst_n = 1'b1;

        issue(4'd0, 32'hFFFF_FFFF, 32'h1, 1'b0, "add_u");          collect(0);
        issue(4'd0, 32'hFFFF_FFFF, 32'h1, 1'b1, "add_s");          collect(0);
        issue(4'd1, 32'h5,         32'h7, 1'b1, "sub");            collect(0);
        issue(4'd4, 32'h8000_0000, 32'h24, 1'b0, "sra");           collect(0);
        issue(4'd2, 32'h8000_0000, 32'h24, 1'b0, "sll");           collect(0);
        issue(4'd3, 32'h8000_0000, 32'h3F, 1'b0, "srl");           collect(0);
        issue(4'd8, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mul");    collect(0);
        issue(4'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, "mulhu");  collect(5);
        issue(4'd10, 32'd100, 32'd7, 1'b0, "divu");                collect(0);
        issue(4'd11, 32'd100, 32'd7, 1'b0, "remu");                collect(0);
        issue(4'd10, 32'h1234_5678, 32'd0, 1'b0, "divu_zero");     collect(0);
        issue(4'd11, 32'd5, 32'd0, 1'b0, "remu_zero");             collect(0);
        issue(4'd13, 32'h1, 32'h2, 1'b0, "op13");                  collect(0);
        issue(4'd7, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b0, "and_after_ill"); collect(0);
        issue(4'd10, 32'd9, 32'd3, 1'b0, "op10");                  collect(0);
        issue(4'd11, 32'd9, 32'd4, 1'b0, "op11");                  collect(0);
        issue(4'd6, 32'h0F00, 32'h00F0, 1'b1, "or_after_div");     collect(0);

        for (int i = 0; i < 12; i++) begin
            issue(4'($urandom_range(0, 15)), $urandom, $urandom, 1'($urandom), "rnd");
            collect(0);
        end

        // Reset part-way through a multiply: the op must vanish without a result.
        issue(4'd8, 32'h0123_4567, 32'h89AB_CDEF, 1'b0, "mul_rst");
        repeat (9) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        void'(sb.pop_front());
        chk("midrst_valid",  out_valid, 0);
        chk("midrst_ready",  in_ready,  1);
        chk("midrst_result", ALUResult, 0);
        chk("midrst_ges",    GES,       0);
        repeat (40) @(posedge clk);
        #1;
        chk("midrst_no_result", out_valid, 0);
        issue(4'd0, 32'd5, 32'd7, 1'b0, "add_post_rst");           collect(0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
